sw_job_sequencer: RTL and testbench

//  Synthesizable on-chip host for FPGAWrapper. Replaces bench-driven stimulus with a stored job list.
//  One run: pulse set_t, wait for the core to go idle, then for each of up to MAX_JOBS score sets:

---
 rtl/sw_job_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_sw_job_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_job_sequencer.sv
// On-chip host for the scoring core: pulses set_t, walks a stored list of score sets,
// collects one result per job into a readable buffer, and aborts a hung core with a watchdog.
module sw_job_sequencer #(
    parameter int MAX_JOBS  = 2,
    parameter int RESULT_W  = 16,
    parameter int SETUP_CYC = 1,
    parameter int TIMEOUT   = 50000,
    parameter int IDX_W     = (MAX_JOBS > 1) ? $clog2(MAX_JOBS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_go,
    input  logic [IDX_W:0]      i_job_cnt,
    input  logic                i_param_we,
    input  logic [IDX_W-1:0]    i_param_addr,
    input  logic [15:0]         i_param_wdata,
    input  logic [IDX_W-1:0]    i_rd_addr,
    output logic [RESULT_W-1:0] o_rd_data,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error,
    output logic [1:0]          o_err_phase,
    output logic [IDX_W:0]      o_jobs_done,
    output logic                o_set_t,
    output logic                o_start_cal,
    output logic [3:0]          o_match,
    output logic [3:0]          o_mismatch,
    output logic [3:0]          o_minusAlpha,
    output logic [3:0]          o_minusBeta,
    input  logic                i_busy,
    input  logic                i_valid,
    input  logic [RESULT_W-1:0] i_result
);

    localparam int CNT_MAX = (TIMEOUT > SETUP_CYC) ? TIMEOUT : SETUP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] WD_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [IDX_W:0]   MAX_CNT    = (IDX_W + 1)'(MAX_JOBS);

    typedef enum logic [3:0] {
        S_IDLE, S_SETT, S_GUARD_T, S_WAIT_T, S_LOAD, S_START,
        S_GUARD_V, S_WAIT_V, S_WAIT_B, S_DONE, S_ERR
    } state_e;

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W:0]        job_q;
    logic [IDX_W:0]        count_q;
    logic [IDX_W:0]        jobs_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic [1:0]            phase_q;
    logic                  set_t_q;
    logic                  start_q;
    logic [15:0]           score_q;
    logic [RESULT_W-1:0]   rd_q;

    logic [15:0]           param_mem  [MAX_JOBS];
    logic [RESULT_W-1:0]   result_mem [MAX_JOBS];

    logic [IDX_W:0]        job_d;
    logic [IDX_W:0]        go_cnt;
    logic                  wd_expire;
    logic                  capture;
    logic                  job_end;

    // Core handshake: i_valid is a 1-cycle result strobe seen only in WAIT_V;
    // the job is finished once i_busy is low (same cycle as valid, or later).
    assign job_d     = job_q + 1'b1;
    assign go_cnt    = (i_job_cnt > MAX_CNT) ? MAX_CNT : i_job_cnt;
    assign wd_expire = (cnt_q == WD_LAST);
    assign capture   = (state_q == S_WAIT_V) && i_valid;
    assign job_end   = ((state_q == S_WAIT_V) && i_valid && !i_busy) ||
                       ((state_q == S_WAIT_B) && !i_busy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            job_q   <= '0;
            count_q <= '0;
            jobs_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            phase_q <= 2'd0;
            set_t_q <= 1'b0;
            start_q <= 1'b0;
            score_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (i_go) begin
                    state_q <= S_SETT;
                    busy_q  <= 1'b1;
                    set_t_q <= 1'b1;
                    err_q   <= 1'b0;
                    phase_q <= 2'd0;
                    jobs_q  <= '0;
                    job_q   <= '0;
                    count_q <= go_cnt;
                end
                S_SETT: begin
                    set_t_q <= 1'b0;
                    state_q <= S_GUARD_T;
                end
                S_GUARD_T: begin
                    state_q <= S_WAIT_T;
                    cnt_q   <= '0;
                end
                S_WAIT_T: if (!i_busy) begin
                    if (count_q == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_LOAD;
                        cnt_q   <= '0;
                        score_q <= param_mem[job_q[IDX_W-1:0]];
                    end
                end else if (wd_expire) begin
                    state_q <= S_ERR;
                    err_q   <= 1'b1;
                    phase_q <= 2'd1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                S_LOAD: if (cnt_q == SETUP_LAST) begin
                    state_q <= S_START;
                    start_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                S_START: begin
                    start_q <= 1'b0;
                    state_q <= S_GUARD_V;
                end
                S_GUARD_V: begin
                    state_q <= S_WAIT_V;
                    cnt_q   <= '0;
                end
                S_WAIT_V: if (i_valid) begin
                    jobs_q <= jobs_q + 1'b1;
                    if (i_busy) begin
                        state_q <= S_WAIT_B;
                        cnt_q   <= '0;
                    end
                end else if (wd_expire) begin
                    state_q <= S_ERR;
                    err_q   <= 1'b1;
                    phase_q <= 2'd2;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                S_WAIT_B: if (i_busy) begin
                    if (wd_expire) begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                        phase_q <= 2'd3;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_ERR: begin
                    set_t_q <= 1'b0;
                    start_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
            // Job completion shared by WAIT_V (coincident busy drop) and WAIT_B.
            if (job_end) begin
                job_q <= job_d;
                if (job_d == count_q) begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= S_LOAD;
                    cnt_q   <= '0;
                    score_q <= param_mem[job_d[IDX_W-1:0]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_param_we && !busy_q && (32'(i_param_addr) < MAX_JOBS))
            param_mem[i_param_addr] <= i_param_wdata;
        if (capture)
            result_mem[job_q[IDX_W-1:0]] <= i_result;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_q <= '0;
        else
            rd_q <= (32'(i_rd_addr) < MAX_JOBS) ? result_mem[i_rd_addr] : '0;
    end

    assign o_rd_data   = rd_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_error     = err_q;
    assign o_err_phase = phase_q;
    assign o_jobs_done = jobs_q;
    assign o_set_t     = set_t_q;
    assign o_start_cal = start_q;
    assign {o_match, o_mismatch, o_minusAlpha, o_minusBeta} = score_q;

endmodule

// File: tb/tb_sw_job_sequencer.sv
// Bench for sw_job_sequencer: behavioural core model, pulse/latency monitor and
// per-run expectations derived from the job-list rules.
module tb_sw_job_sequencer;

    localparam int MAX_JOBS  = 2;
    localparam int RESULT_W  = 16;
    localparam int SETUP_CYC = 1;
    localparam int TIMEOUT   = 100;
    localparam int IDX_W     = 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                i_go = 1'b0;
    logic [IDX_W:0]      i_job_cnt = '0;
    logic                i_param_we = 1'b0;
    logic [IDX_W-1:0]    i_param_addr = '0;
    logic [15:0]         i_param_wdata = '0;
    logic [IDX_W-1:0]    i_rd_addr = '0;
    logic [RESULT_W-1:0] o_rd_data;
    logic                o_busy, o_done, o_error;
    logic [1:0]          o_err_phase;
    logic [IDX_W:0]      o_jobs_done;
    logic                o_set_t, o_start_cal;
    logic [3:0]          o_match, o_mismatch, o_minusAlpha, o_minusBeta;
    logic                i_busy = 1'b0;
    logic                i_valid = 1'b0;
    logic [RESULT_W-1:0] i_result = '0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_set_t, n_start, n_done;
    logic [15:0]         shadow [MAX_JOBS];
    logic [RESULT_W-1:0] exp_q[$];

    int t_len = 2, v_lat = 40, tail = 3;
    bit coinc = 1'b0, hang_v = 1'b0, core_kick = 1'b0;
    bit arm = 1'b0;
    int b_cyc = -1, earliest = 0;

    sw_job_sequencer #(
        .MAX_JOBS(MAX_JOBS), .RESULT_W(RESULT_W), .SETUP_CYC(SETUP_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_go(i_go), .i_job_cnt(i_job_cnt),
        .i_param_we(i_param_we), .i_param_addr(i_param_addr), .i_param_wdata(i_param_wdata),
        .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data), .o_busy(o_busy), .o_done(o_done),
        .o_error(o_error), .o_err_phase(o_err_phase), .o_jobs_done(o_jobs_done),
        .o_set_t(o_set_t), .o_start_cal(o_start_cal), .o_match(o_match),
        .o_mismatch(o_mismatch), .o_minusAlpha(o_minusAlpha), .o_minusBeta(o_minusBeta),
        .i_busy(i_busy), .i_valid(i_valid), .i_result(i_result)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Core model: busy after set_t for t_len cycles; after start, result valid
    // v_lat cycles later, busy dropping with it (coinc) or tail cycles after.
    initial begin : core_model
        int cph;
        int ccnt;
        cph  = 0;
        ccnt = 0;
        forever begin
            @(posedge clk);
            #1;
            i_valid = 1'b0;
            if (!rst_n || core_kick) begin
                cph = 0;
                i_busy = 1'b0;
                core_kick = 1'b0;
            end else begin
                case (cph)
                    0: if (o_set_t) begin
                        i_busy = 1'b1; ccnt = t_len; cph = 1;
                    end else if (o_start_cal) begin
                        i_busy = 1'b1; ccnt = v_lat; cph = 2;
                    end
                    1, 3: if (ccnt == 0) begin
                        i_busy = 1'b0; cph = 0;
                    end else begin
                        ccnt--;
                    end
                    2: if (!hang_v) begin
                        if (ccnt == 0) begin
                            i_valid  = 1'b1;
                            i_result = RESULT_W'($urandom);
                            exp_q.push_back(i_result);
                            if (coinc) begin
                                i_busy = 1'b0; cph = 0;
                            end else begin
                                ccnt = tail; cph = 3;
                            end
                        end else begin
                            ccnt--;
                        end
                    end
                    default: cph = 0;
                endcase
            end
        end
    end

    // Monitor: counts pulse cycles and checks that each start/done follows the
    // cycle in which the core was seen idle (LOAD next cycle, START SETUP_CYC later).
    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                arm = 1'b0;
            end else begin
                if (arm && b_cyc < 0 && cyc >= earliest && !i_busy) b_cyc = cyc;
                if (o_start_cal) begin
                    if (n_start < MAX_JOBS)
                        check_eq("score_at_start", {o_match, o_mismatch, o_minusAlpha, o_minusBeta},
                                 shadow[n_start]);
                    check_eq("start_armed", arm, 1);
                    check_eq("start_latency", cyc, b_cyc + 1 + SETUP_CYC);
                    n_start++;
                    arm = 1'b0;
                end
                if (o_done) begin
                    check_eq("done_armed", arm, 1);
                    check_eq("done_latency", cyc, b_cyc + 1);
                    n_done++;
                    arm = 1'b0;
                end
                if (o_set_t) begin
                    n_set_t++;
                    arm = 1'b1; b_cyc = -1; earliest = cyc + 2;
                end
                if (i_valid) begin
                    arm = 1'b1; b_cyc = i_busy ? -1 : cyc; earliest = cyc;
                end
            end
        end
    end

    task automatic write_param(input int addr, input logic [15:0] data);
        i_param_we = 1'b1;
        i_param_addr = IDX_W'(addr);
        i_param_wdata = data;
        @(posedge clk);
        #1;
        i_param_we = 1'b0;
        shadow[addr] = data;
    endtask

    task automatic run_job(input int cnt, input bit poke, input int exp_phase);
        int n;
        int cycles;
        n = (cnt > MAX_JOBS) ? MAX_JOBS : cnt;
        exp_q.delete();
        n_set_t = 0; n_start = 0; n_done = 0;
        i_go = 1'b1;
        i_job_cnt = (IDX_W + 1)'(cnt);
        @(posedge clk);
        #1;
        i_go = 1'b0;
        check_eq("go_busy", o_busy, 1);
        check_eq("go_clears_error", {o_error, o_err_phase}, 0);
        check_eq("go_clears_jobs", o_jobs_done, 0);
        cycles = 0;
        while (o_busy && cycles < 2000) begin
            if (poke && cycles == 15) begin
                i_go = 1'b1; i_job_cnt = (IDX_W + 1)'(1);
                i_param_we = 1'b1; i_param_addr = IDX_W'($urandom); i_param_wdata = 16'($urandom);
            end
            @(posedge clk);
            #1;
            i_go = 1'b0; i_param_we = 1'b0;
            cycles++;
        end
        check_eq("run_ends", o_busy, 0);
        if (exp_phase == 0) begin
            check_eq("set_t_cycles", n_set_t, 1);
            check_eq("start_cycles", n_start, n);
            check_eq("done_cycles", n_done, 1);
            check_eq("jobs_done", o_jobs_done, n);
            check_eq("no_error", {o_error, o_err_phase}, 0);
            if (n > 0)
                check_eq("score_hold", {o_match, o_mismatch, o_minusAlpha, o_minusBeta}, shadow[n-1]);
            for (int k = 0; k < n; k++) begin
                i_rd_addr = IDX_W'(k);
                @(posedge clk);
                #1;
                check_eq("result", o_rd_data, (k < exp_q.size()) ? exp_q[k] : 'x);
            end
        end else begin
            check_eq("err_done_cycles", n_done, 0);
            check_eq("err_flag", {o_error, o_err_phase}, {1'b1, 2'(exp_phase)});
            check_eq("err_jobs_done", o_jobs_done, exp_q.size());
            check_eq("err_start_cycles", n_start, (exp_phase == 1) ? 0 : 1);
            check_eq("wd_time", (cycles >= TIMEOUT && cycles <= TIMEOUT + 60), 1);
            core_kick = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq("stays_idle", o_busy, 0);
    endtask

    initial begin : stimulus
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ctrl", {o_busy, o_done, o_error, o_err_phase, o_set_t, o_start_cal, o_jobs_done}, 0);
        check_eq("rst_score", {o_match, o_mismatch, o_minusAlpha, o_minusBeta}, 0);
        check_eq("rst_rd", o_rd_data, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        write_param(0, 16'h2311);
        write_param(1, 16'h1212);

        run_job(2, 1'b0, 0);
        run_job(0, 1'b0, 0);
        hang_v = 1'b1; v_lat = 5;
        run_job(2, 1'b0, 2);
        hang_v = 1'b0;
        run_job(2, 1'b0, 0);
        t_len = 300;
        run_job(1, 1'b0, 1);
        t_len = 2; tail = 300;
        run_job(2, 1'b0, 3);
        tail = 3; coinc = 1'b1; v_lat = 6;
        run_job(2, 1'b0, 0);
        coinc = 1'b0; v_lat = 30;
        run_job(2, 1'b1, 0);
        run_job(3, 1'b0, 0);

        // Asynchronous reset while the core is computing
        v_lat = 60;
        i_go = 1'b1; i_job_cnt = (IDX_W + 1)'(2);
        @(posedge clk);
        #1;
        i_go = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_ctrl", {o_busy, o_done, o_error, o_err_phase, o_set_t, o_start_cal, o_jobs_done}, 0);
        check_eq("rst_mid_score", {o_match, o_mismatch, o_minusAlpha, o_minusBeta}, 0);
        check_eq("rst_mid_rd", o_rd_data, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        v_lat = 12;
        run_job(2, 1'b0, 0);

        for (int r = 0; r < 12; r++) begin
            for (int a = 0; a < MAX_JOBS; a++)
                if ($urandom_range(0, 1) == 1) write_param(a, 16'($urandom));
            t_len = $urandom_range(0, 5);
            v_lat = $urandom_range(1, 40);
            tail  = $urandom_range(0, 4);
            coinc = 1'($urandom_range(0, 1));
            run_job($urandom_range(0, 3), 1'b0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
